// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D-cache refill arbiter.
// Block geometry, address/word types and the arbiter state encoding.
package mem_arb_pkg;

  localparam int PC_SIZE     = 32;
  localparam int MEMORY_WORD = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int BEAT_W      = $clog2(BLOCK_WORDS);
  localparam int OFF         = BEAT_W + 2;

  typedef logic [PC_SIZE-1:0]     addr_t;
  typedef logic [MEMORY_WORD-1:0] word_t;
  typedef logic [BEAT_W-1:0]      beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte address of one word inside the block holding base.
  function automatic addr_t beat_addr(
    input addr_t base,
    input beat_t beat
  );
    return {base[PC_SIZE-1:OFF], beat, 2'b00};
  endfunction

endpackage

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one RAM port between I-cache refills
// and D-cache refills / single-word writes.
module mem_refill_arbiter
  import mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  ic_req,
  input  addr_t ic_addr,
  input  logic  dc_req,
  input  logic  dc_we,
  input  addr_t dc_addr,
  input  word_t dc_wdata,
  input  word_t ram_rdata,
  input  logic  ram_ready,
  output logic  ram_req,
  output logic  ram_we,
  output addr_t ram_addr,
  output word_t ram_wdata,
  output word_t rdata,
  output logic  ic_word_valid,
  output logic  dc_word_valid,
  output logic  ic_done,
  output logic  dc_done
);

  state_t state;
  beat_t  beat;
  logic   gnt_dc;
  logic   last_dc;
  addr_t  base;
  word_t  wbuf;

  logic pick_dc;
  logic any_req;
  logic last_beat;
  logic lsb_unused;

  assign any_req   = ic_req | dc_req;
  // On a tie the D-cache wins only if the I-cache was served last.
  assign pick_dc   = dc_req & (~ic_req | ~last_dc);
  assign last_beat = (beat == BEAT_W'(BLOCK_WORDS - 1));
  assign lsb_unused = ^base[1:0];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      beat    <= '0;
      gnt_dc  <= 1'b0;
      last_dc <= 1'b1;
      base    <= '0;
      wbuf    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_dc <= pick_dc;
            base   <= pick_dc ? dc_addr : ic_addr;
            wbuf   <= dc_wdata;
            state  <= (pick_dc & dc_we) ? WRITE : BURST;
          end
        end
        BURST: begin
          if (ram_ready) begin
            beat <= last_beat ? '0 : beat + BEAT_W'(1);
            if (last_beat) state <= DONE;
          end
        end
        WRITE: begin
          if (ram_ready) state <= DONE;
        end
        DONE: begin
          last_dc <= gnt_dc;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs are held low while reset is asserted.
  always_comb begin
    ram_req       = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    rdata         = '0;
    ic_word_valid = 1'b0;
    dc_word_valid = 1'b0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    if (nrst) begin
      rdata = ram_rdata;
      unique case (state)
        IDLE: ;
        BURST: begin
          ram_req       = 1'b1;
          ram_addr      = beat_addr(base, beat);
          ic_word_valid = ram_ready & ~gnt_dc;
          dc_word_valid = ram_ready & gnt_dc;
        end
        WRITE: begin
          ram_req   = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = {base[PC_SIZE-1:2], 2'b00};
          ram_wdata = wbuf;
        end
        DONE: begin
          ic_done = ~gnt_dc;
          dc_done = gnt_dc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter: request queues feed the DUT,
// a RAM model answers, expected beats and done pulses are queued up front.
module tb_mem_refill_arbiter;
  import mem_arb_pkg::*;

  localparam word_t K = 32'h5A5A_0000;

  typedef struct {
    logic  dc;
    logic  we;
    addr_t addr;
    word_t wdata;
  } exp_t;

  typedef struct {
    logic  we;
    addr_t addr;
    word_t wdata;
  } dreq_t;

  typedef struct {
    logic  dc;
    logic  we;
    addr_t addr;
    word_t wdata;
    int    waits;
    addr_t exp_base;
    int    exp_lat;
  } vec_t;

  logic  clk = 1'b0;
  logic  nrst = 1'b0;
  logic  ic_req = 1'b0;
  addr_t ic_addr = '0;
  logic  dc_req = 1'b0;
  logic  dc_we = 1'b0;
  addr_t dc_addr = '0;
  word_t dc_wdata = '0;
  word_t ram_rdata;
  logic  ram_ready = 1'b0;
  logic  ram_req;
  logic  ram_we;
  addr_t ram_addr;
  word_t ram_wdata;
  word_t rdata;
  logic  ic_word_valid;
  logic  dc_word_valid;
  logic  ic_done;
  logic  dc_done;

  exp_t  exp_q[$];
  logic  done_q[$];
  addr_t ic_q[$];
  dreq_t dc_q[$];
  exp_t  mon_e;
  vec_t  tv[6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int done_cyc = 0;
  int valid_cnt = 0;
  int wr_cycles = 0;
  int beats_seen = 0;
  int waits = 0;
  int wcnt = 0;
  logic pulse_rdy = 1'b0;
  logic mon_en = 1'b0;
  logic any_q = 1'b0;

  mem_refill_arbiter dut (
    .clk(clk),
    .nrst(nrst),
    .ic_req(ic_req),
    .ic_addr(ic_addr),
    .dc_req(dc_req),
    .dc_we(dc_we),
    .dc_addr(dc_addr),
    .dc_wdata(dc_wdata),
    .ram_rdata(ram_rdata),
    .ram_ready(ram_ready),
    .ram_req(ram_req),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .rdata(rdata),
    .ic_word_valid(ic_word_valid),
    .dc_word_valid(dc_word_valid),
    .ic_done(ic_done),
    .dc_done(dc_done)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram_addr ^ K;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Requesters: each holds its request while its queue is non-empty.
  always @(posedge clk) begin
    #1;
    ic_req  = (ic_q.size() != 0);
    ic_addr = ic_req ? ic_q[0] : '0;
    dc_req  = (dc_q.size() != 0);
    if (dc_req) begin
      dc_we    = dc_q[0].we;
      dc_addr  = dc_q[0].addr;
      dc_wdata = dc_q[0].wdata;
    end else begin
      dc_we    = 1'b0;
      dc_addr  = '0;
      dc_wdata = '0;
    end
    if (!any_q && (ic_req || dc_req)) rise_cyc = cyc;
    any_q = ic_req || dc_req;
  end

  // RAM: `waits` low cycles before each accepted word.
  always @(posedge clk) begin
    #2;
    if (!ram_req || ram_ready) wcnt = 0;
    if (pulse_rdy) ram_ready = 1'b1;
    else if (ram_req && wcnt >= waits) ram_ready = 1'b1;
    else begin
      ram_ready = 1'b0;
      if (ram_req) wcnt++;
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      if (mon_en)
        chk("reset_outs_zero",
            |{ram_req, ram_we, ram_addr, ram_wdata, rdata,
              ic_word_valid, dc_word_valid, ic_done, dc_done}, 0);
    end else if (mon_en) begin
      chk("valid_vs_ready", ic_word_valid | dc_word_valid,
          ram_req & ram_ready & ~ram_we);
      if (ram_we) wr_cycles++;
      if (ic_word_valid || dc_word_valid) valid_cnt++;
      if (ram_req) begin
        if (exp_q.size() == 0) chk("unexpected_ram_req", 1, 0);
        else begin
          mon_e = exp_q[0];
          chk("ram_addr", ram_addr, mon_e.addr);
          chk("ram_we", ram_we, mon_e.we);
          if (mon_e.we) chk("ram_wdata", ram_wdata, mon_e.wdata);
          if (ram_ready) begin
            if (!mon_e.we) begin
              chk("ic_word_valid", ic_word_valid, !mon_e.dc);
              chk("dc_word_valid", dc_word_valid, mon_e.dc);
              chk("rdata", rdata, mon_e.addr ^ K);
            end else begin
              chk("no_valid_on_write", ic_word_valid | dc_word_valid, 0);
            end
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (ic_done || dc_done) begin
        chk("done_outside_access", ram_req, 0);
        done_cyc = cyc;
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("done_who", {ic_done, dc_done}, done_q[0] ? 2'b01 : 2'b10);
          void'(done_q.pop_front());
        end
        if (ic_done && ic_q.size() != 0) void'(ic_q.pop_front());
        if (dc_done && dc_q.size() != 0) void'(dc_q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic dc, input logic we,
                          input addr_t base, input word_t wd);
    exp_t b;
    int n;
    n = we ? 1 : BLOCK_WORDS;
    for (int i = 0; i < n; i++) begin
      b.dc = dc;
      b.we = we;
      b.addr = base + addr_t'(4 * i);
      b.wdata = wd;
      exp_q.push_back(b);
    end
    done_q.push_back(dc);
  endtask

  task automatic push_ic(input addr_t a, input addr_t base);
    push_exp(1'b0, 1'b0, base, '0);
    ic_q.push_back(a);
  endtask

  task automatic push_dc(input logic we, input addr_t a, input word_t wd,
                         input addr_t base);
    dreq_t r;
    push_exp(1'b1, we, base, wd);
    r.we = we;
    r.addr = a;
    r.wdata = wd;
    dc_q.push_back(r);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, (exp_q.size() != 0 || done_q.size() != 0), 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int n;
    tv[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 0, 32'h0000_1230, 5};
    tv[1] = '{1'b1, 1'b1, 32'h0000_2006, 32'hDEAD_BEEF, 3, 32'h0000_2004, 5};
    tv[2] = '{1'b1, 1'b0, 32'h0000_4010, 32'h0, 2, 32'h0000_4010, 13};
    tv[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, 32'hFFFF_FFF0, 9};
    tv[4] = '{1'b1, 1'b1, 32'h0000_0003, 32'h1234_5678, 0, 32'h0, 2};
    tv[5] = '{1'b1, 1'b0, 32'h8000_001F, 32'h0, 0, 32'h8000_0010, 5};

    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_reset",
        |{ram_req, ram_we, ic_word_valid, dc_word_valid, ic_done, dc_done}, 0);

    pulse_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("idle_ready_ignored",
          {ram_req, ram_we, ic_word_valid, dc_word_valid, ic_done, dc_done}, 0);
    end
    pulse_rdy = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      waits = tv[i].waits;
      valid_cnt = 0;
      wr_cycles = 0;
      if (tv[i].dc) push_dc(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].exp_base);
      else push_ic(tv[i].addr, tv[i].exp_base);
      wait_drain("vec", 200);
      chk("done_latency", done_cyc - rise_cyc, tv[i].exp_lat);
      chk("valid_count", valid_cnt, tv[i].we ? 0 : BLOCK_WORDS);
      chk("write_cycles", wr_cycles, tv[i].we ? tv[i].waits + 1 : 0);
    end

    // Round-robin: I-cache re-requests immediately, so D-cache wins the retie.
    nrst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    waits = 0;
    push_ic(32'h0000_1000, 32'h0000_1000);
    push_dc(1'b0, 32'h0000_3008, 32'h0, 32'h0000_3000);
    push_ic(32'h0000_1100, 32'h0000_1100);
    wait_drain("tie", 300);

    // Reset two beats into a refill: abandoned, then restarted from beat 0.
    waits = 0;
    b0 = beats_seen;
    push_ic(32'h0000_5000, 32'h0000_5000);
    n = 0;
    while (beats_seen < b0 + 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("beats_before_reset", beats_seen - b0, 2);
    @(posedge clk);
    #1 nrst = 1'b0;
    exp_q.delete();
    done_q.delete();
    push_exp(1'b0, 1'b0, 32'h0000_5000, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    wait_drain("reset_restart", 100);

    chk("queues_empty",
        ic_q.size() + dc_q.size() + exp_q.size() + done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
